writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Shares the single write-back port of global_register between NUM_REQUESTERS execution units. Each unit has a valid/ready handshake.
- Selects one requester per cycle with round-robin priority and registers the winner's descriptor and result.
- Drives global_register's write_back_input, write_back_register_input and result_input one cycle after acceptance, which releases the write-reserve bit.

Parameters:
- NUM_REQUESTERS, 4, number of execution units competing for write-back (>=2).
- REQ_ID_WIDTH, $clog2(NUM_REQUESTERS), derived localparam; width of grant index.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- req_valid_input  input  NUM_REQUESTERS  per-requester result valid
- req_register_input  input  NUM_REQUESTERS x REGISTER_DESCRIPTOR_WIDTH  destination register per requester
- req_result_input  input  NUM_REQUESTERS x OPERAND_WIDTH  result data per requester
- req_ready_output  output  NUM_REQUESTERS  one-hot accept strobe
- stall_input  input  1  blocks all acceptance this cycle
- write_back_output  output  1  write strobe to register file
- write_back_register_output  output  REGISTER_DESCRIPTOR_WIDTH  write destination
- result_output  output  OPERAND_WIDTH  write data
- grant_id_output  output  REQ_ID_WIDTH  index of requester whose write is on the outputs

Behaviour:
- Reset (rst low, async): all registered outputs are 0; priority pointer ptr is 0. req_ready_output is all 0 while rst is low.
- Arbitration (combinational):
  - Scan the requesters starting at ptr, wrapping modulo NUM_REQUESTERS.
  - The first requester with valid=1 wins.
  - req_ready_output[win]=1 only when stall_input=0; all other ready bits are 0.
  - ready may depend on valid; valid must never depend on ready.
- Accept: a transfer occurs when valid&ready is true in a cycle.
- On the next rising edge after an accept:
  - write_back_register_output and result_output take the winner's values.
  - grant_id_output takes win.
  - write_back_output takes 1, except when the descriptor is 0 (see register 0 below).
  - ptr takes (win+1) mod NUM_REQUESTERS, with explicit wrap from NUM_REQUESTERS-1 to 0.
- No accept (no valid, or stall_input=1): on the next edge write_back_output is 0; data, register, grant_id and ptr hold.
- Latency: exactly one cycle from accept to write_back_output=1. Throughput is one write per cycle.
- Register 0: the transfer is accepted and ptr advances, but write_back_output stays 0. Register 0 is hard-wired and has no cell.
- Requester protocol: while valid=1 and ready=0, the requester holds valid, register and result stable.
- Simultaneous requests: at most one ready per cycle. Losers wait. Every valid requester is granted within NUM_REQUESTERS accept cycles.
- stall_input asserted mid-burst: no ready is raised. Pending requesters keep valid, and ptr is unchanged.
- Reset mid-operation: an in-flight registered write is discarded, write_back_output drops to 0 asynchronously, and ptr returns to 0.

Optional Feature:
- Macro: WRITEBACK_FORWARD_EN.
- Defined: adds three ports, all combinational, valid in the accept cycle (one cycle before the register file updates):
  - fwd_valid_output (1): 1 on an accept with a nonzero descriptor.
  - fwd_register_output (REGISTER_DESCRIPTOR_WIDTH): the winner's descriptor.
  - fwd_result_output (OPERAND_WIDTH): the winner's result.
  - Issue logic uses these to bypass.
- Undefined: these ports and their logic are absent. No other behaviour changes.

Decomposition:
- register_params package gains NUM_WB_REQUESTERS (default 4) and typedef wb_req_t, a struct of register descriptor and operand, used for the request arrays.
- REGISTER_DESCRIPTOR_WIDTH and OPERAND_WIDTH are reused from register_params.
- One sub-module, rr_priority_picker: a combinational rotate, find-first and unrotate over NUM_REQUESTERS. Inputs are valid vector and ptr; outputs are one-hot grant, win index and any_valid.

Test Plan:
- Reset: hold rst=0 with all valid=1 -> ready=0000, write_back_output=0. Release rst -> first edge accepts requester 0 (ptr=0), and write_back_output=1 the next cycle with its register and data.
- Round robin: valid=1111 held for 8 cycles with distinct descriptors 1..4 -> grant_id sequence 0,1,2,3,0,1,2,3, one write per cycle.
- Sparse: only requester 2 valid, reg=5, data=0xDEAD_BEEF -> ready[2]=1 immediately; the next cycle has write_back_output=1, reg=5, result=0xDEAD_BEEF, grant_id=2; ptr=3.
- Register 0: requester 1 valid with reg=0 -> ready[1]=1 and ptr advances, but write_back_output stays 0. With WRITEBACK_FORWARD_EN, fwd_valid_output=0.
- Stall: valid=0101, stall_input=1 for 3 cycles -> ready=0000 and write_back_output=0 throughout. Release stall -> requester 0 is granted, then requester 2 one cycle later.
- Async reset mid-burst: assert rst low between edges while write_back_output=1 -> write_back_output drops to 0 without a clock edge. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and widths for the write-back arbiter.
// Optional feature macro: WRITEBACK_FORWARD_EN (see writeback_arbiter.sv).
package writeback_arbiter_pkg;

    localparam int unsigned REGISTER_DESCRIPTOR_WIDTH = 5;
    localparam int unsigned OPERAND_WIDTH             = 32;
    localparam int unsigned NUM_WB_REQUESTERS         = 4;

    // One pending write-back request: destination register and its data.
    typedef struct packed {
        logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_descriptor;
        logic [OPERAND_WIDTH-1:0]             operand;
    } wb_req_t;

    // Register 0 is hard-wired; a write to it must not reach the register file.
    function automatic logic writes_cell(input logic [REGISTER_DESCRIPTOR_WIDTH-1:0] desc);
        return desc != '0;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Request-side handshake bundle between execution units and the write-back arbiter.
interface writeback_arbiter_if
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = NUM_WB_REQUESTERS
);
    logic [NUM_REQUESTERS-1:0]                                req_valid_input;
    logic [NUM_REQUESTERS-1:0][REGISTER_DESCRIPTOR_WIDTH-1:0] req_register_input;
    logic [NUM_REQUESTERS-1:0][OPERAND_WIDTH-1:0]             req_result_input;
    logic [NUM_REQUESTERS-1:0]                                req_ready_output;
    logic                                                     stall_input;

    // Execution-unit side.
    modport master (
        output req_valid_input,
        output req_register_input,
        output req_result_input,
        output stall_input,
        input  req_ready_output
    );

    // Arbiter side.
    modport slave (
        input  req_valid_input,
        input  req_register_input,
        input  req_result_input,
        input  stall_input,
        output req_ready_output
    );
endinterface

// File: rtl/writeback_arbiter_rr_priority_picker.sv
// Round-robin find-first: first valid requester at or after ptr, wrapping.
module writeback_arbiter_rr_priority_picker #(
    parameter int unsigned NUM_REQUESTERS = 4,
    localparam int unsigned REQ_ID_WIDTH  = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] valid_i,
    input  logic [REQ_ID_WIDTH-1:0]   ptr_i,
    output logic [NUM_REQUESTERS-1:0] grant_o,
    output logic [REQ_ID_WIDTH-1:0]   win_o,
    output logic                      any_valid_o
);

    // Scan offsets from farthest to nearest so the nearest valid slot wins.
    always_comb begin
        int unsigned             idx;
        logic [REQ_ID_WIDTH-1:0] idx_w;
        win_o = '0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            idx = 32'(ptr_i) + (NUM_REQUESTERS - 1 - k);
            if (idx >= NUM_REQUESTERS) begin
                idx = idx - NUM_REQUESTERS;
            end
            idx_w = REQ_ID_WIDTH'(idx);
            if (valid_i[idx_w]) begin
                win_o = idx_w;
            end
        end
    end

    // One-hot grant derived from the winning index.
    always_comb begin
        grant_o = '0;
        if (any_valid_o) begin
            grant_o[win_o] = 1'b1;
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write-back port.
// Define WRITEBACK_FORWARD_EN to expose the accept-cycle bypass ports.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = NUM_WB_REQUESTERS,
    localparam int unsigned REQ_ID_WIDTH  = $clog2(NUM_REQUESTERS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    writeback_arbiter_if.slave                   bus,
    output logic                                 write_back_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] write_back_register_output,
    output logic [OPERAND_WIDTH-1:0]             result_output,
`ifdef WRITEBACK_FORWARD_EN
    output logic                                 fwd_valid_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] fwd_register_output,
    output logic [OPERAND_WIDTH-1:0]             fwd_result_output,
`endif
    output logic [REQ_ID_WIDTH-1:0]              grant_id_output
);

    wb_req_t                                req [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0]              grant;
    logic [REQ_ID_WIDTH-1:0]                win;
    logic                                   any_valid;
    logic                                   accept;

    logic [REQ_ID_WIDTH-1:0]                ptr_q, ptr_d;
    logic                                   wb_q, wb_d;
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0]   reg_q, reg_d;
    logic [OPERAND_WIDTH-1:0]               res_q, res_d;
    logic [REQ_ID_WIDTH-1:0]                gid_q, gid_d;

    // Bundle the per-requester fields into request structs.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            req[i].register_descriptor = bus.req_register_input[i];
            req[i].operand             = bus.req_result_input[i];
        end
    end

    writeback_arbiter_rr_priority_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_picker (
        .valid_i     (bus.req_valid_input),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .win_o       (win),
        .any_valid_o (any_valid)
    );

    // Ready is gated by reset so nothing is accepted while rst is held low.
    assign accept               = rst && !bus.stall_input && any_valid;
    assign bus.req_ready_output = accept ? grant : '0;

`ifdef WRITEBACK_FORWARD_EN
    assign fwd_valid_output    = accept && writes_cell(req[win].register_descriptor);
    assign fwd_register_output = req[win].register_descriptor;
    assign fwd_result_output   = req[win].operand;
`endif

    // Next-state: capture the winner on accept, otherwise hold data and drop the strobe.
    always_comb begin
        ptr_d = ptr_q;
        wb_d  = 1'b0;
        reg_d = reg_q;
        res_d = res_q;
        gid_d = gid_q;
        if (accept) begin
            reg_d = req[win].register_descriptor;
            res_d = req[win].operand;
            gid_d = win;
            wb_d  = writes_cell(req[win].register_descriptor);
            ptr_d = (win == REQ_ID_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : win + REQ_ID_WIDTH'(1);
        end
    end

    // State registers; async reset discards any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            wb_q  <= 1'b0;
            reg_q <= '0;
            res_q <= '0;
            gid_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            wb_q  <= wb_d;
            reg_q <= reg_d;
            res_q <= res_d;
            gid_q <= gid_d;
        end
    end

    assign write_back_output          = wb_q;
    assign write_back_register_output = reg_q;
    assign result_output              = res_q;
    assign grant_id_output            = gid_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed steps then randomized traffic
// compared against a simple round-robin reference model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb;
    logic [4:0]  wb_reg;
    logic [31:0] wb_res;
    logic [1:0]  gid;
`ifdef WRITEBACK_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_res;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_ptr;
    logic        m_wb;
    logic [4:0]  m_reg;
    logic [31:0] m_res;
    logic [1:0]  m_gid;
    logic [3:0]  last_acc;

    writeback_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

    writeback_arbiter #(.NUM_REQUESTERS(N)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .bus                        (bus),
        .write_back_output          (wb),
        .write_back_register_output (wb_reg),
        .result_output              (wb_res),
`ifdef WRITEBACK_FORWARD_EN
        .fwd_valid_output           (fwd_valid),
        .fwd_register_output        (fwd_reg),
        .fwd_result_output          (fwd_res),
`endif
        .grant_id_output            (gid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wb = 1'b0; m_reg = '0; m_res = '0; m_gid = '0; last_acc = '0;
    endtask

    // Called just after a falling edge with inputs already driven; ends 1 time unit past
    // the following rising edge with all outputs compared.
    task automatic cycle();
        int         win;
        logic [3:0] er;
        #1;
        win = -1;
        er  = '0;
        if (rst && !bus.stall_input) begin
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (m_ptr + off) % N;
                if (bus.req_valid_input[idx] && win < 0) win = idx;
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("ready", 64'(bus.req_ready_output), 64'(er));
`ifdef WRITEBACK_FORWARD_EN
        chk("fwd_valid", 64'(fwd_valid),
            64'(win >= 0 && bus.req_register_input[(win < 0) ? 0 : win] != 0));
        if (win >= 0) begin
            chk("fwd_reg", 64'(fwd_reg), 64'(bus.req_register_input[win]));
            chk("fwd_res", 64'(fwd_res), 64'(bus.req_result_input[win]));
        end
`endif
        last_acc = er;
        if (win >= 0) begin
            m_reg = bus.req_register_input[win];
            m_res = bus.req_result_input[win];
            m_gid = 2'(win);
            m_wb  = (m_reg != 0);
            m_ptr = (win + 1) % N;
        end else begin
            m_wb = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("wb", 64'(wb), 64'(m_wb));
        chk("wb_reg", 64'(wb_reg), 64'(m_reg));
        chk("wb_res", 64'(wb_res), 64'(m_res));
        chk("grant_id", 64'(gid), 64'(m_gid));
    endtask

    initial begin
        // Reset held with every requester valid.
        rst = 1'b0;
        bus.stall_input = 1'b0;
        bus.req_valid_input = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.req_register_input[i] = 5'(i + 1);
            bus.req_result_input[i]   = 32'h1000_0000 + 32'(i);
        end
        model_reset();
        #3;
        chk("rst_ready", 64'(bus.req_ready_output), 64'(0));
        chk("rst_wb", 64'(wb), 64'(0));
        @(posedge clk); #1;
        chk("rst_ready_edge", 64'(bus.req_ready_output), 64'(0));
        chk("rst_wb_edge", 64'(wb), 64'(0));
        chk("rst_gid", 64'(gid), 64'(0));

        // Release reset: requester 0 wins first, then strict rotation.
        @(negedge clk); rst = 1'b1;
        cycle();
        chk("first_gid", 64'(gid), 64'(0));
        chk("first_reg", 64'(wb_reg), 64'(1));
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            cycle();
            chk("rr_gid", 64'(gid), 64'(k % N));
            chk("rr_wb", 64'(wb), 64'(1));
        end

        // Sparse: only requester 2.
        @(negedge clk);
        bus.req_valid_input = 4'b0100;
        bus.req_register_input[2] = 5'd5;
        bus.req_result_input[2]   = 32'hDEAD_BEEF;
        cycle();
        chk("sparse_wb", 64'(wb), 64'(1));
        chk("sparse_reg", 64'(wb_reg), 64'(5));
        chk("sparse_res", 64'(wb_res), 64'hDEAD_BEEF);
        chk("sparse_gid", 64'(gid), 64'(2));

        // Register 0: accepted, no write strobe, pointer still advances (3 -> scan hits 1 -> 2).
        @(negedge clk);
        bus.req_valid_input = 4'b0010;
        bus.req_register_input[1] = 5'd0;
        cycle();
        chk("r0_wb", 64'(wb), 64'(0));
        chk("r0_gid", 64'(gid), 64'(1));
        @(negedge clk);
        bus.req_valid_input = 4'b1111;
        bus.req_register_input[1] = 5'd9;
        cycle();
        chk("r0_ptr", 64'(gid), 64'(2));

        // Stall with 0101 pending for three cycles, then release.
        @(negedge clk);
        bus.req_valid_input = 4'b0101;
        bus.stall_input = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_wb", 64'(wb), 64'(0));
            @(negedge clk);
        end
        bus.stall_input = 1'b0;
        cycle();
        chk("unstall_gid0", 64'(gid), 64'(0));
        @(negedge clk);
        bus.req_valid_input = bus.req_valid_input & ~last_acc;
        cycle();
        chk("unstall_gid2", 64'(gid), 64'(2));
        chk("unstall_wb", 64'(wb), 64'(1));

        // Async reset while a write is on the outputs.
        @(negedge clk);
        bus.req_valid_input = 4'b1111;
        cycle();
        chk("pre_rst_wb", 64'(wb), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("async_wb", 64'(wb), 64'(0));
        chk("async_gid", 64'(gid), 64'(0));
        chk("async_ready", 64'(bus.req_ready_output), 64'(0));
        model_reset();
        @(negedge clk); rst = 1'b1;
        cycle();
        chk("restart_gid", 64'(gid), 64'(0));

        // Randomized traffic; a requester holds its request until it is accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid_input[i] && !last_acc[i])) begin
                    bus.req_valid_input[i]    = 1'($urandom_range(0, 1));
                    bus.req_register_input[i] = 5'($urandom_range(0, 31));
                    bus.req_result_input[i]   = $urandom;
                end
            end
            bus.stall_input = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
